axis_upsize_64_512: RTL and testbench
=====================================

Name: axis_upsize_64_512

Overview:
- AXI4-Stream width upsizer. Packs 64-bit network-side beats into 512-bit words.
- Sits directly upstream of the 512-bit AXI-stream register slice in the network kernel datapath and drives that slice's slave port.
- Preserves packet boundaries. A packet's tail closes the current wide word early, with unfilled lanes marked invalid in tkeep.

Parameters:
- IN_WIDTH, 64, input tdata width in bits; must be a multiple of 8.
- RATIO, 8, input beats per output word; output width = IN_WIDTH*RATIO = 512.

Ports:
- aclk  in  1  sole clock; all logic is rising-edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tdata  in  IN_WIDTH  input data.
- s_axis_tkeep  in  IN_WIDTH/8  input byte enables.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  IN_WIDTH*RATIO  packed output data; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
- m_axis_tkeep  out  IN_WIDTH*RATIO/8  packed byte enables.
- m_axis_tlast  out  1  output word closes a packet.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0.
  - Lane counter=0; accumulator data and keep cleared.
  - s_axis_tready=0 while areset is high.
- Storage:
  - Accumulator register: RATIO lanes of data and keep.
  - Lane counter: log2(RATIO) bits.
  - One output register holding m_axis_*.
- s_axis_tready = !areset && (!m_axis_tvalid || m_axis_tready). This is combinational from m_axis_tready; no other gating.
- Input handshake (s_axis_tvalid && s_axis_tready):
  - Write tdata/tkeep into lane = lane counter.
  - The beat closes the word if s_axis_tlast=1 or lane==RATIO-1.
  - Closing beat:
    - Load the output register with the accumulator contents including the current beat, in the same edge.
    - Lanes above the current lane get data=0 and keep=0.
    - m_axis_tlast = s_axis_tlast.
    - Clear the accumulator; lane counter resets to 0.
  - Non-closing beat: lane counter += 1.
- Latency: m_axis_tvalid rises the cycle after the closing input handshake.
- Throughput: one input beat per cycle sustained while the output drains.
- Output handshake: m_axis_tvalid stays high and m_axis_* stay stable until m_axis_tready. This is standard AXIS; a held word is never modified.
- Simultaneous output drain and closing input beat: output register reloads in the same edge; m_axis_tvalid stays 1 (no bubble).
- Input beat with tkeep=0: still occupies a lane; no compaction.
- tlast at lane 0: single-lane output word, m_axis_tkeep = {56'b0, s_tkeep}.
- Full word without tlast: m_axis_tlast=0; the packet continues in the next word at lane 0.
- Reset mid-packet: partial accumulator and any held output word are discarded; no output after release until a new closing beat.
- No packet-length, error or tuser handling.

Optional Feature:
- Macro: AXIS_UPSIZE_STATS_EN.
- With the macro defined, extra output ports:
  - stat_pkt_cnt  out 32: increments on every output handshake with m_axis_tlast=1.
  - stat_word_cnt  out 32: increments on every output handshake.
  - stat_partial_cnt  out 32: increments when an emitted word has any keep bit clear.
- Counter rules: all three reset to 0 on areset and wrap modulo 2^32.
- Without the macro: ports and counters absent; datapath behaviour identical.

Decomposition:
- Package axis_upsize_pkg:
  - localparams OUT_WIDTH, IN_KEEP_W, OUT_KEEP_W, LANE_W=$clog2(RATIO).
  - typedef lane_idx_t.
  - typedef stat_cnt_t (32-bit).
- Single module; no sub-module needed. The statistics block is an in-module generate region under the macro.

Test Plan:
- 8 beats, data 0x01..0x08, keep 0xFF, tlast on beat 8, m_tready=1 → one word: lanes 0..7 = 0x01..0x08, tkeep all ones, tlast=1, valid on the cycle after beat 8.
- 3-beat packet, last tkeep=0x0F → tkeep = 0x0000_0000_000F_FFFF (lanes 0,1 full, lane 2 low 4 bytes), data lanes 3..7 zero, tlast=1.
- 20-beat packet → three words: lanes 8/8/4, tlast=0/0/1; third word tkeep = lower 32 bits set.
- m_tready held 0 with a word pending → s_tready=0; output stable for 10 cycles. Release m_tready together with a closing beat → back-to-back words, no bubble, no beat lost.
- Assert areset after 5 beats of a packet → outputs zero immediately (async). After release, a 2-beat packet yields exactly one word with only lanes 0–1 set.
- With AXIS_UPSIZE_STATS_EN: send 20-beat and 3-beat packets → stat_pkt_cnt=2, stat_word_cnt=4, stat_partial_cnt=2.

Source files
------------

// File: rtl/axis_upsize_64_512_pkg.sv
// Purpose: shared widths and types for the 64-to-512 AXI-Stream upsizer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: default geometry, derived widths, the lane index type, the statistics counter type
// and a helper that flags words with unfilled byte lanes.
package axis_upsize_pkg;

    localparam int DEF_IN_WIDTH = 64;
    localparam int DEF_RATIO    = 8;

    localparam int OUT_WIDTH  = DEF_IN_WIDTH * DEF_RATIO;
    localparam int IN_KEEP_W  = DEF_IN_WIDTH / 8;
    localparam int OUT_KEEP_W = OUT_WIDTH / 8;
    localparam int LANE_W     = $clog2(DEF_RATIO);

    typedef logic [LANE_W-1:0] lane_idx_t;
    typedef logic [31:0]       stat_cnt_t;

    // True when at least one byte of a wide word is not valid (short or sparse word).
    function automatic logic keep_has_hole(input logic [OUT_KEEP_W-1:0] keep);
        return ~&keep;
    endfunction

endpackage

// File: rtl/axis_upsize_64_512_if.sv
// Purpose: one AXI-Stream channel (valid/ready, data, byte keep, last) of configurable width.
// Latency: n/a (wiring only).
// Backpressure: tready flows from slave modport back to master modport.
// Ports: master drives tvalid/tdata/tkeep/tlast and samples tready; slave is the mirror.
interface axis_upsize_64_512_if #(
    parameter int DATA_W = 64
) ();

    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/axis_upsize_64_512.sv
// Purpose: packs 64-bit AXI-Stream beats into 512-bit words; a packet tail closes the word early.
// Latency: output word valid one cycle after the closing input handshake.
// Backpressure: input ready = !areset && (output empty || downstream ready); a held word never changes.
// Ports: aclk, areset (async, active high), s_axis (narrow slave), m_axis (wide master).
// Optional: define AXIS_UPSIZE_STATS_EN to add stat_pkt_cnt, stat_word_cnt, stat_partial_cnt.
module axis_upsize_64_512
    import axis_upsize_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int RATIO    = DEF_RATIO
) (
    input  logic                        aclk,
    input  logic                        areset,
    axis_upsize_64_512_if.slave         s_axis,
    axis_upsize_64_512_if.master        m_axis
`ifdef AXIS_UPSIZE_STATS_EN
    ,
    output stat_cnt_t                   stat_pkt_cnt,
    output stat_cnt_t                   stat_word_cnt,
    output stat_cnt_t                   stat_partial_cnt
`endif
);

    localparam int WORD_W    = IN_WIDTH * RATIO;
    localparam int IN_KW     = IN_WIDTH / 8;
    localparam int WORD_KW   = WORD_W / 8;
    localparam int LANE_BITS = (RATIO > 1) ? $clog2(RATIO) : 1;

    // Accumulator and fill pointer
    logic [LANE_BITS-1:0]               lane;
    logic [RATIO-1:0][IN_WIDTH-1:0]     acc_dat;
    logic [RATIO-1:0][IN_KW-1:0]        acc_keep;

    // Word as it would leave if the current beat closes it
    logic [RATIO-1:0][IN_WIDTH-1:0]     word_dat;
    logic [RATIO-1:0][IN_KW-1:0]        word_keep;

    // Output register
    logic                               out_vld;
    logic [WORD_W-1:0]                  out_dat;
    logic [WORD_KW-1:0]                 out_keep;
    logic                               out_last;

    logic                               in_rdy;
    logic                               in_fire;
    logic                               close_word;

    // The output register is the only storage that can block; the input
    // accepts whenever that register is empty or is being drained this cycle.
    assign in_rdy        = !areset && (!out_vld || m_axis.tready);
    assign s_axis.tready = in_rdy;
    assign in_fire       = s_axis.tvalid && in_rdy;
    assign close_word    = s_axis.tlast || (lane == LANE_BITS'(RATIO - 1));

    // Lanes below the fill pointer come from the accumulator, the current
    // lane from the live beat, and lanes above are forced empty so a short
    // word never carries stale bytes.
    always_comb begin
        word_dat  = '0;
        word_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (LANE_BITS'(k) == lane) begin
                word_dat[k]  = s_axis.tdata;
                word_keep[k] = s_axis.tkeep;
            end else if (LANE_BITS'(k) < lane) begin
                word_dat[k]  = acc_dat[k];
                word_keep[k] = acc_keep[k];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lane     <= '0;
            acc_dat  <= '0;
            acc_keep <= '0;
        end else if (in_fire) begin
            if (close_word) begin
                lane     <= '0;
                acc_dat  <= '0;
                acc_keep <= '0;
            end else begin
                acc_dat[lane]  <= s_axis.tdata;
                acc_keep[lane] <= s_axis.tkeep;
                lane           <= lane + LANE_BITS'(1);
            end
        end
    end

    // A closing beat reloads the register even while the previous word is
    // draining, so back-to-back words leave without a bubble.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_keep <= '0;
            out_last <= 1'b0;
        end else if (in_fire && close_word) begin
            out_vld  <= 1'b1;
            out_dat  <= word_dat;
            out_keep <= word_keep;
            out_last <= s_axis.tlast;
        end else if (out_vld && m_axis.tready) begin
            out_vld  <= 1'b0;
        end
    end

    assign m_axis.tvalid = out_vld;
    assign m_axis.tdata  = out_dat;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tlast  = out_last;

`ifdef AXIS_UPSIZE_STATS_EN
    logic out_fire;
    assign out_fire = out_vld && m_axis.tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stat_pkt_cnt     <= '0;
            stat_word_cnt    <= '0;
            stat_partial_cnt <= '0;
        end else if (out_fire) begin
            stat_word_cnt <= stat_word_cnt + 32'd1;
            if (out_last) begin
                stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            end
            if (keep_has_hole(out_keep)) begin
                stat_partial_cnt <= stat_partial_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_upsize_64_512.sv
module tb_axis_upsize_64_512;

    logic aclk;
    logic areset;

    axis_upsize_64_512_if #(.DATA_W(64))  s_if ();
    axis_upsize_64_512_if #(.DATA_W(512)) m_if ();

`ifdef AXIS_UPSIZE_STATS_EN
    logic [31:0] stat_pkt_cnt, stat_word_cnt, stat_partial_cnt;
`endif

    axis_upsize_64_512 dut (
        .aclk   (aclk),
        .areset (areset),
        .s_axis (s_if),
        .m_axis (m_if)
`ifdef AXIS_UPSIZE_STATS_EN
        ,
        .stat_pkt_cnt     (stat_pkt_cnt),
        .stat_word_cnt    (stat_word_cnt),
        .stat_partial_cnt (stat_partial_cnt)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Downstream ready: 0 = always 1, 1 = manual, 2 = random
    int   rdy_mode;
    logic manual_rdy;
    logic rnd_rdy;
    assign m_if.tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? manual_rdy : rnd_rdy;

    initial begin
        rnd_rdy = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    int checks;
    int errors;

    typedef struct {
        logic [511:0] dat;
        logic [63:0]  keep;
        logic         last;
    } exp_t;

    exp_t exp_q[$];

    // Packet under construction
    logic [63:0] pkt_dat[$];
    logic [7:0]  pkt_keep[$];

    int unsigned mdl_pkts, mdl_words, mdl_partials;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference: chop the packet into groups of 8 beats; beat i sits in lane i%8
    // of word i/8; the final group is the packet end.
    task automatic model_packet();
        int len = pkt_dat.size();
        for (int w = 0; w * 8 < len; w++) begin
            exp_t e;
            e.dat  = '0;
            e.keep = '0;
            for (int j = 0; j < 8; j++) begin
                int idx = w * 8 + j;
                if (idx < len) begin
                    e.dat[j*64 +: 64] = pkt_dat[idx];
                    e.keep[j*8 +: 8]  = pkt_keep[idx];
                end
            end
            e.last = (w * 8 + 8 >= len);
            exp_q.push_back(e);
            mdl_words++;
            if (e.last) mdl_pkts++;
            if (e.keep != {64{1'b1}}) mdl_partials++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        forever begin
            @(negedge aclk);
            if (s_if.tready) break;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL input_timeout: s_tready stayed 0 for %0d cycles", n);
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic run_packet(input bit gaps);
        model_packet();
        for (int i = 0; i < pkt_dat.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge aclk);
                    #1;
                end
            end
            send_beat(pkt_dat[i], pkt_keep[i], i == pkt_dat.size() - 1);
        end
    endtask

    task automatic build_seq(input int len, input logic [63:0] base, input logic [7:0] last_keep);
        pkt_dat.delete();
        pkt_keep.delete();
        for (int i = 0; i < len; i++) begin
            pkt_dat.push_back(base + 64'(i));
            pkt_keep.push_back(i == len - 1 ? last_keep : 8'hFF);
        end
    endtask

    task automatic build_rand(input int len);
        pkt_dat.delete();
        pkt_keep.delete();
        for (int i = 0; i < len; i++) begin
            pkt_dat.push_back({$urandom, $urandom});
            pkt_keep.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge aclk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
        end
    endtask

    // Output monitor: pops the scoreboard on every output handshake and checks
    // that a stalled word holds still.
    logic         held;
    logic [576:0] held_word;
    exp_t         mon_e;

    initial held = 1'b0;

    always @(negedge aclk) begin
        if (areset) begin
            held = 1'b0;
        end else if (m_if.tvalid) begin
            if (held) begin
                checks++;
                if ({m_if.tdata, m_if.tkeep, m_if.tlast} !== held_word) begin
                    errors++;
                    $display("FAIL held_stable: word changed while stalled, keep %0h expected %0h",
                             m_if.tkeep, held_word[64:1]);
                end
            end
            if (m_if.tready) begin
                checks++;
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got keep %0h last %0b, expected no word",
                             m_if.tkeep, m_if.tlast);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (m_if.tdata !== mon_e.dat || m_if.tkeep !== mon_e.keep ||
                        m_if.tlast !== mon_e.last) begin
                        errors++;
                        $display("FAIL out_word: got keep %0h last %0b data %0h expected keep %0h last %0b data %0h",
                                 m_if.tkeep, m_if.tlast, m_if.tdata, mon_e.keep, mon_e.last, mon_e.dat);
                    end
                end
            end else begin
                held      = 1'b1;
                held_word = {m_if.tdata, m_if.tkeep, m_if.tlast};
            end
        end else begin
            if (held) begin
                checks++;
                errors++;
                $display("FAIL held_dropped: tvalid fell to 0 without handshake, expected 1");
            end
            held = 1'b0;
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        mdl_pkts     = 0;
        mdl_words    = 0;
        mdl_partials = 0;
        rdy_mode     = 0;
        manual_rdy   = 1'b0;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = '0;
        s_if.tkeep   = '0;
        s_if.tlast   = 1'b0;
        areset       = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_s_tready", 512'(s_if.tready), 512'(0));
        check("rst_m_tvalid", 512'(m_if.tvalid), 512'(0));
        check("rst_m_tdata",  m_if.tdata, 512'(0));
        check("rst_m_tkeep",  512'(m_if.tkeep), 512'(0));
        check("rst_m_tlast",  512'(m_if.tlast), 512'(0));
`ifdef AXIS_UPSIZE_STATS_EN
        check("rst_stat_word", 512'(stat_word_cnt), 512'(0));
`endif
        @(posedge aclk);
        #2;
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // Full 8-beat packet; valid the cycle after the closing beat
        build_seq(8, 64'h1, 8'hFF);
        check("idle_m_tvalid", 512'(m_if.tvalid), 512'(0));
        run_packet(1'b0);
        @(negedge aclk);
        check("latency_8beat", 512'(m_if.tvalid), 512'(1));
        @(posedge aclk);
        #1;
        drain();

        // 3-beat packet with a partial tail
        build_seq(3, 64'hA0, 8'h0F);
        run_packet(1'b0);
        drain();

        // 20-beat packet spans three words
        build_seq(20, 64'h1000, 8'hFF);
        run_packet(1'b0);
        drain();

        // Backpressure: word held for 10 cycles, then release with a closing beat
        rdy_mode   = 1;
        manual_rdy = 1'b0;
        build_seq(8, 64'h200, 8'hFF);
        run_packet(1'b0);
        repeat (10) begin
            @(negedge aclk);
            check("bp_s_tready", 512'(s_if.tready), 512'(0));
            check("bp_m_tvalid", 512'(m_if.tvalid), 512'(1));
        end
        @(posedge aclk);
        #1;
        build_seq(1, 64'hBEEF, 8'h3C);
        model_packet();
        manual_rdy  = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 64'hBEEF;
        s_if.tkeep  = 8'h3C;
        s_if.tlast  = 1'b1;
        @(negedge aclk);
        check("release_s_tready", 512'(s_if.tready), 512'(1));
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        @(negedge aclk);
        check("no_bubble", 512'(m_if.tvalid), 512'(1));
        @(posedge aclk);
        #1;
        drain();
        rdy_mode = 0;

        // Randomized packets with random gaps and random downstream ready
        rdy_mode = 2;
        for (int p = 0; p < 60; p++) begin
            build_rand($urandom_range(1, 20));
            run_packet(1'b1);
        end
        drain();
        rdy_mode = 0;
        @(posedge aclk);
        #1;

        // Reset in the middle of a packet
        build_seq(5, 64'h7700, 8'hFF);
        for (int i = 0; i < 5; i++) send_beat(pkt_dat[i], pkt_keep[i], 1'b0);
        @(posedge aclk);
        #2;
        areset = 1'b1;
        #1;
        check("arst_m_tvalid", 512'(m_if.tvalid), 512'(0));
        check("arst_m_tdata",  m_if.tdata, 512'(0));
        check("arst_m_tkeep",  512'(m_if.tkeep), 512'(0));
        check("arst_m_tlast",  512'(m_if.tlast), 512'(0));
        check("arst_s_tready", 512'(s_if.tready), 512'(0));
        mdl_pkts     = 0;
        mdl_words    = 0;
        mdl_partials = 0;
        repeat (2) @(posedge aclk);
        #2;
        areset = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            check("post_rst_quiet", 512'(m_if.tvalid), 512'(0));
        end
        @(posedge aclk);
        #1;
        build_seq(2, 64'h5500, 8'hFF);
        run_packet(1'b0);
        drain();

        // 20-beat and 3-beat packets feed the statistics
        build_seq(20, 64'h3000, 8'hFF);
        run_packet(1'b1);
        build_seq(3, 64'h4000, 8'hFF);
        run_packet(1'b1);
        drain();
        repeat (2) @(posedge aclk);
        #1;
`ifdef AXIS_UPSIZE_STATS_EN
        check("stat_pkt_cnt",     512'(stat_pkt_cnt),     512'(mdl_pkts));
        check("stat_word_cnt",    512'(stat_word_cnt),    512'(mdl_words));
        check("stat_partial_cnt", 512'(stat_partial_cnt), 512'(mdl_partials));
`endif
        check("final_idle", 512'(m_if.tvalid), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
